// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int ofs_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/instr_cache_data_ram.sv
// Flop-based data array of the instruction cache.
// It has one synchronous write port and one combinational read port.
module instr_cache_data_ram
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [idx_width(LINES)-1:0]           wr_index,
  input  logic [ofs_width(WORDS_PER_LINE)-1:0]  wr_word,
  input  logic [31:0]                           wr_data,
  input  logic [idx_width(LINES)-1:0]           rd_index,
  input  logic [ofs_width(WORDS_PER_LINE)-1:0]  rd_word,
  output logic [31:0]                           rd_data
);

  logic [31:0] mem [LINES][WORDS_PER_LINE];

  // refill write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_index][wr_word] <= wr_data;
    end
  end

  assign rd_data = mem[rd_index][rd_word];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with a line refill over a req/ack port.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters.
module instr_cache
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr_PC,
  input  logic        i_con_req,
  input  logic        i_con_flush,
  output logic [31:0] o_data_Instr,
  output logic        o_con_stall,
  output logic [31:0] o_addr_Mem,
  output logic        o_con_mem_req,
  input  logic        i_con_mem_ack,
  input  logic [31:0] i_data_Mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] o_cnt_hit,
  output logic [31:0] o_cnt_miss
`endif
);

  localparam int OW = ofs_width(WORDS_PER_LINE);
  localparam int IW = idx_width(LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [OW-1:0] LAST_W = OW'(WORDS_PER_LINE - 1);

  logic [OW-1:0] ofs;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          unused_byte_bits;

  assign ofs = i_addr_PC[OW+1:2];
  assign idx = i_addr_PC[OW+IW+1:OW+2];
  assign tag = i_addr_PC[31:OW+IW+2];
  assign unused_byte_bits = ^i_addr_PC[1:0];

  state_t        state, state_nxt;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [TW-1:0] tag_l;
  logic [IW-1:0] idx_l;
  logic [OW-1:0] w;
  logic          mem_req_r;
  logic [31:0]   mem_addr_r;
  logic          stale;
  logic          hit, miss, ack_ok, ram_we;
  logic [31:0]   ram_rdata;

  instr_cache_data_ram #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data_ram (
    .clk      (i_clk),
    .we       (ram_we),
    .wr_index (idx_l),
    .wr_word  (w),
    .wr_data  (i_data_Mem),
    .rd_index (idx),
    .rd_word  (ofs),
    .rd_data  (ram_rdata)
  );

  // hit detection, core-facing outputs and next state
  always_comb begin
    state_nxt    = state;
    hit          = 1'b0;
    ack_ok       = i_con_mem_ack & mem_req_r;
    ram_we       = 1'b0;
    if (i_con_req && (state == IDLE) && valid[idx] && (tags[idx] == tag)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    miss         = i_con_req & ~hit & (state == IDLE);
    o_con_stall  = (i_con_req & ~hit) | (state != IDLE);
    o_data_Instr = hit ? ram_rdata : NOP;
    case (state)
      IDLE: begin
        if (miss) state_nxt = REFILL;
        else      state_nxt = IDLE;
      end
      REFILL: begin
        ram_we = ack_ok;
        if (ack_ok && (w == LAST_W)) state_nxt = FILL_DONE;
        else                         state_nxt = REFILL;
      end
      FILL_DONE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM state, refill bookkeeping and registered memory request
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      tag_l      <= '0;
      idx_l      <= '0;
      w          <= '0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0000_0000;
      stale      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (miss) begin
            tag_l      <= tag;
            idx_l      <= idx;
            w          <= '0;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {tag, idx, {OW{1'b0}}, 2'b00};
            stale      <= 1'b0;
          end
        end
        REFILL: begin
          if (ack_ok) begin
            w <= w + 1'b1;
            if (w == LAST_W) mem_req_r  <= 1'b0;
            else             mem_addr_r <= {tag_l, idx_l, w + 1'b1, 2'b00};
          end
          // a flush while filling means the incoming line may be stale
          if (i_con_flush) stale <= 1'b1;
        end
        FILL_DONE: begin
          if (i_con_flush) stale <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // valid bits and tag array; flush overrides a completing fill
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid <= '0;
      for (int i = 0; i < LINES; i++) tags[i] <= '0;
    end else if (i_con_flush) begin
      valid <= '0;
    end else if ((state == FILL_DONE) && !stale) begin
      valid[idx_l] <= 1'b1;
      tags[idx_l]  <= tag_l;
    end
  end

  assign o_con_mem_req = mem_req_r;
  assign o_addr_Mem    = mem_addr_r;

`ifdef ICACHE_STATS_EN
  // saturating hit/miss statistics
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_hit  <= 32'h0000_0000;
      o_cnt_miss <= 32'h0000_0000;
    end else if (i_con_flush) begin
      o_cnt_hit  <= 32'h0000_0000;
      o_cnt_miss <= 32'h0000_0000;
    end else begin
      if (hit && (o_cnt_hit != 32'hFFFF_FFFF))   o_cnt_hit  <= o_cnt_hit + 32'd1;
      if (miss && (o_cnt_miss != 32'hFFFF_FFFF)) o_cnt_miss <= o_cnt_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache with a req/ack memory model.
// Memory word at address A is A + 32'h1000_0000.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_pc;
  logic        req, flush;
  logic [31:0] data_instr;
  logic        stall;
  logic [31:0] addr_mem;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] cnt_hit, cnt_miss;
`endif

  int total = 0;
  int bad   = 0;
  int wait_n = 0;
  int wcnt   = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] mem_log [$];

  instr_cache dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_addr_PC     (addr_pc),
    .i_con_req     (req),
    .i_con_flush   (flush),
    .o_data_Instr  (data_instr),
    .o_con_stall   (stall),
    .o_addr_Mem    (addr_mem),
    .o_con_mem_req (mem_req),
    .i_con_mem_ack (mem_ack),
    .i_data_Mem    (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .o_cnt_hit     (cnt_hit),
    .o_cnt_miss    (cnt_miss)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: acks after wait_n idle cycles, checks the address is held while waiting
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_req) begin
      if (prev_req && !prev_ack) check("addr_hold", addr_mem, prev_addr);
      if (wcnt == wait_n) begin
        mem_ack  = 1'b1;
        mem_data = addr_mem + 32'h1000_0000;
        mem_log.push_back(addr_mem);
        wcnt     = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    prev_req  = mem_req & ~rst;
    prev_ack  = mem_ack;
    prev_addr = addr_mem;
  end

  // fetch until the stall clears; n returns the number of stalled cycles
  task automatic fetch(input logic [31:0] a, output int n);
    n = 0;
    @(posedge clk); #1;
    addr_pc = a; req = 1'b1; flush = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        req;
    logic        flush;
    logic        exp_stall;
    logic [31:0] exp_data;
    logic        exp_mem_req;
  } vec_t;

  vec_t vecs [7];
  int   n;

  initial begin
    vecs[0] = '{32'h0000_0044, 1'b1, 1'b0, 1'b0, 32'h1000_0044, 1'b0};
    vecs[1] = '{32'h0000_0048, 1'b1, 1'b0, 1'b0, 32'h1000_0048, 1'b0};
    vecs[2] = '{32'h0000_004C, 1'b1, 1'b0, 1'b0, 32'h1000_004C, 1'b0};
    vecs[3] = '{32'h0000_0040, 1'b1, 1'b0, 1'b0, 32'h1000_0040, 1'b0};
    vecs[4] = '{32'h0000_004C, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0000_0044, 1'b1, 1'b1, 1'b0, 32'h1000_0044, 1'b0};
    vecs[6] = '{32'h0000_0044, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

    rst = 1'b1; req = 1'b0; flush = 1'b0; addr_pc = 32'h0000_0040;
    mem_ack = 1'b0; mem_data = 32'h0;
    #12;
    check("rst_stall_noreq", 32'(stall), 32'd0);
    check("rst_data", data_instr, 32'h0000_0000);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", addr_mem, 32'h0000_0000);
    req = 1'b1; #1;
    check("rst_stall_req", 32'(stall), 32'd1);
    req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // cold miss
    mem_log.delete();
    fetch(32'h0000_0040, n);
    check("cold_stall_cycles", 32'(n), 32'd6);
    check("cold_data", data_instr, 32'h1000_0040);
    check("cold_log_size", 32'(mem_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < mem_log.size(); i++)
      check("cold_mem_addr", mem_log[i], 32'h0000_0040 + 32'(4 * i));

    // line hits, flush alongside a hit, then the miss that follows
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      addr_pc = vecs[i].addr; req = vecs[i].req; flush = vecs[i].flush;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_data", i), data_instr, vecs[i].exp_data);
      check($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].exp_mem_req));
    end
    fetch(32'h0000_0044, n);
    check("after_flush_remaining_stall", 32'(n), 32'd5);
    check("after_flush_data", data_instr, 32'h1000_0044);

    // conflict eviction on index 0
    fetch(32'h0000_0000, n);
    check("conf_a_stall", 32'(n), 32'd6);
    check("conf_a_data", data_instr, 32'h1000_0000);
    mem_log.delete();
    fetch(32'h0000_0100, n);
    check("conf_b_stall", 32'(n), 32'd6);
    check("conf_b_data", data_instr, 32'h1000_0100);
    check("conf_b_first_addr", (mem_log.size() > 0) ? mem_log[0] : 32'hFFFF_FFFF, 32'h0000_0100);
    fetch(32'h0000_0000, n);
    check("conf_a_again_stall", 32'(n), 32'd6);

    // wait states
    wait_n = 3;
    fetch(32'h0000_0200, n);
    check("wait_stall_cycles", 32'(n), 32'd18);
    check("wait_data", data_instr, 32'h1000_0200);
    @(posedge clk); #1; wait_n = 0;

    // flush coinciding with the second ack
    req = 1'b0; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    mem_log.delete();
    @(posedge clk); #1; addr_pc = 32'h0000_0040; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    fetch(32'h0000_0040, n);
    check("flush_mid_stall", 32'(n), 32'd9);
    check("flush_mid_data", data_instr, 32'h1000_0040);
    check("flush_mid_log_size", 32'(mem_log.size()), 32'd8);
    check("flush_mid_rerequest", (mem_log.size() > 4) ? mem_log[4] : 32'hFFFF_FFFF, 32'h0000_0040);

    // reset after the first ack
    @(posedge clk); #1; addr_pc = 32'h0000_0080; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1; #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall_req", 32'(stall), 32'd1);
    check("rst_mid_data", data_instr, 32'h0000_0000);
    req = 1'b0; #1;
    check("rst_mid_stall_noreq", 32'(stall), 32'd0);
    rst = 1'b0;
    fetch(32'h0000_0040, n);
    check("post_rst_miss_40", 32'(n), 32'd6);
    check("post_rst_data_40", data_instr, 32'h1000_0040);
    fetch(32'h0000_0080, n);
    check("post_rst_miss_80", 32'(n), 32'd6);
    check("post_rst_data_80", data_instr, 32'h1000_0080);

    @(posedge clk); #1; req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
